// File: rtl/gpio_pad_ctrl.sv
// gpio_pad_ctrl: registered pad drive, 2-flop input sync, per-pin glitch filter
// and sticky edge-pending bits for one pad bank.
module gpio_pad_ctrl #(
    parameter int NPINS  = 8,
    parameter int FILT_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NPINS-1:0]  dir_i,
    input  logic [NPINS-1:0]  out_i,
    input  logic [NPINS-1:0]  od_i,
    input  logic [FILT_W-1:0] filt_len_i,
    input  logic [NPINS-1:0]  rise_en_i,
    input  logic [NPINS-1:0]  fall_en_i,
    input  logic [NPINS-1:0]  pend_clr_i,
    output logic [NPINS-1:0]  pad_oen_o,
    output logic [NPINS-1:0]  pad_i_o,
    input  logic [NPINS-1:0]  pad_o_i,
    output logic [NPINS-1:0]  in_o,
    output logic [NPINS-1:0]  pend_o,
    output logic              irq_o
);
    logic [NPINS-1:0] sync1, sync2, filt, pend, upd;
    logic [FILT_W-1:0] cnt [NPINS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pad_oen_o <= '1;
            pad_i_o   <= '0;
            sync1     <= '0;
            sync2     <= '0;
            filt      <= '0;
            pend      <= '0;
        end else begin
            pad_oen_o <= ~(dir_i & ~(od_i & out_i));
            pad_i_o   <= out_i & ~od_i;
            sync1     <= pad_o_i;
            sync2     <= sync1;
            filt      <= filt ^ upd;
            pend      <= (pend & ~pend_clr_i) | (upd & sync2 & rise_en_i) | (upd & ~sync2 & fall_en_i);
        end
    end

    // cnt counts consecutive samples that disagree with filt; any agreement restarts it
    for (genvar g = 0; g < NPINS; g++) begin : g_filt
        assign upd[g] = (sync2[g] != filt[g]) && (cnt[g] >= filt_len_i);
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                cnt[g] <= '0;
            else
                cnt[g] <= (sync2[g] == filt[g] || upd[g]) ? '0 : cnt[g] + FILT_W'(1);
        end
    end

    assign in_o   = filt;
    assign pend_o = pend;
    assign irq_o  = |pend;
endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// tb_gpio_pad_ctrl: directed test-plan checks plus randomized traffic against a
// cycle-level reference model of the pad controller.
module tb_gpio_pad_ctrl;
    logic       clk = 0;
    logic       rst;
    logic [7:0] dir, out, od, rise_en, fall_en, pend_clr, pad_o;
    logic [3:0] flen;
    logic [7:0] pad_oen, pad_i, in_v, pend;
    logic       irq;

    int n_chk = 0;
    int n_pass = 0;

    logic [7:0] m_oen, m_pi, m_s1, m_s2, m_filt, m_pend;
    int         m_run [8];

    gpio_pad_ctrl #(.NPINS(8), .FILT_W(4)) dut (
        .clk(clk), .rst(rst), .dir_i(dir), .out_i(out), .od_i(od),
        .filt_len_i(flen), .rise_en_i(rise_en), .fall_en_i(fall_en),
        .pend_clr_i(pend_clr), .pad_oen_o(pad_oen), .pad_i_o(pad_i),
        .pad_o_i(pad_o), .in_o(in_v), .pend_o(pend), .irq_o(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_oen = 8'hFF; m_pi = 0; m_s1 = 0; m_s2 = 0; m_filt = 0; m_pend = 0;
        for (int i = 0; i < 8; i++) m_run[i] = 0;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".oen"}, pad_oen, m_oen);
        check({tag, ".pi"}, pad_i, m_pi);
        check({tag, ".in"}, in_v, m_filt);
        check({tag, ".pend"}, pend, m_pend);
        check({tag, ".irq"}, irq, |m_pend);
    endtask

    // One clock: the model decides what the pad bank should look like after the
    // edge from the drive rules and a run-length view of the filter.
    task automatic step(input string tag);
        logic [7:0] rise, fall;
        rise = 0; fall = 0;
        for (int i = 0; i < 8; i++) begin
            if (m_s2[i] != m_filt[i]) begin
                m_run[i]++;
                if (m_run[i] > int'(flen)) begin
                    m_filt[i] = m_s2[i];
                    m_run[i] = 0;
                    if (m_s2[i]) rise[i] = 1; else fall[i] = 1;
                end
            end else m_run[i] = 0;
        end
        m_pend = (m_pend & ~pend_clr) | (rise & rise_en) | (fall & fall_en);
        for (int i = 0; i < 8; i++) begin
            m_oen[i] = !dir[i] ? 1'b1 : (od[i] ? out[i] : 1'b0);
            m_pi[i]  = od[i] ? 1'b0 : out[i];
        end
        m_s2 = m_s1;
        m_s1 = pad_o;
        @(posedge clk); #1;
        check_model(tag);
    endtask

    initial begin
        rst = 1; dir = 0; out = 0; od = 0; rise_en = 0; fall_en = 0; pend_clr = 0;
        pad_o = 8'hFF; flen = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst.oen", pad_oen, 8'hFF);
        check("rst.pi", pad_i, 8'h00);
        check("rst.in", in_v, 8'h00);
        check("rst.pend", pend, 8'h00);
        check("rst.irq", irq, 1'b0);

        #3 rst = 0;
        step("rel1");
        step("rel2");
        check("rel.in_before", in_v, 8'h00);
        step("rel3");
        check("rel.in_after", in_v, 8'hFF);

        dir = 8'h01; out = 8'h01; od = 0;
        step("pp");
        check("pp.oen0", pad_oen[0], 1'b0);
        check("pp.pi0", pad_i[0], 1'b1);
        od = 8'h01;
        step("od1");
        check("od1.oen0", pad_oen[0], 1'b1);
        check("od1.pi0", pad_i[0], 1'b0);
        out = 8'h00;
        step("od0");
        check("od0.oen0", pad_oen[0], 1'b0);
        check("od0.pi0", pad_i[0], 1'b0);

        flen = 3; pad_o = 8'hFB;
        repeat (7) step("settle");
        check("settle.in2", in_v[2], 1'b0);
        pad_o = 8'hFF;
        repeat (3) step("glitch");
        pad_o = 8'hFB;
        repeat (6) step("glitch_tail");
        check("glitch.in2", in_v[2], 1'b0);
        check("glitch.pend", pend, 8'h00);

        rise_en = 8'h04; pad_o = 8'hFF;
        repeat (5) step("hold");
        check("hold.in2_early", in_v[2], 1'b0);
        step("hold6");
        check("hold.in2", in_v[2], 1'b1);
        check("hold.pend2", pend[2], 1'b1);
        check("hold.irq", irq, 1'b1);

        fall_en = 8'h04; pad_o = 8'hFB;
        repeat (5) step("fall");
        pend_clr = 8'h04;
        step("fall6");
        pend_clr = 0;
        check("arb.in2", in_v[2], 1'b0);
        check("arb.pend2", pend[2], 1'b1);
        pend_clr = 8'h04;
        step("clr");
        pend_clr = 0;
        check("clr.pend2", pend[2], 1'b0);
        check("clr.irq", irq, 1'b0);

        flen = 5; pad_o = 8'hFF;
        repeat (4) step("mid");
        #2 rst = 1;
        #1;
        check("arst.oen", pad_oen, 8'hFF);
        check("arst.pi", pad_i, 8'h00);
        check("arst.in", in_v, 8'h00);
        check("arst.pend", pend, 8'h00);
        check("arst.irq", irq, 1'b0);
        model_reset();
        @(negedge clk);
        rst = 0;
        rise_en = 0; fall_en = 0;
        repeat (7) step("restart");
        check("restart.in_early", in_v, 8'h00);
        step("restart8");
        check("restart.in", in_v, 8'hFF);

        for (int c = 0; c < 400; c++) begin
            if (c % 50 == 0) flen = 4'($urandom_range(0, 3));
            for (int i = 0; i < 8; i++)
                if ($urandom_range(0, 5) == 0) pad_o[i] = ~pad_o[i];
            dir = 8'($urandom); out = 8'($urandom); od = 8'($urandom);
            rise_en = 8'($urandom); fall_en = 8'($urandom);
            pend_clr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            step("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
